// File: rtl/axi4_stream_sync_fifo.sv
// Single-clock AXI4-Stream FIFO with tlast sideband, fill-level/almost-full status
// and an optional store-and-forward mode that holds beats until a whole packet is stored.
module axi4_stream_sync_fifo #(
    parameter int DATA_SIZE          = 8,
    parameter int DEPTH              = 16,
    parameter int PACKET_MODE        = 0,
    parameter int ALMOST_FULL_THRESH = DEPTH - 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [DATA_SIZE-1:0]       data_in_tdata,
    input  logic                       data_in_tlast,
    input  logic                       data_in_tvalid,
    output logic                       data_in_tready,
    output logic [DATA_SIZE-1:0]       data_out_tdata,
    output logic                       data_out_tlast,
    output logic                       data_out_tvalid,
    input  logic                       data_out_tready,
    output logic [$clog2(DEPTH):0]     fill_level_o,
    output logic                       almost_full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(ALMOST_FULL_THRESH);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [DATA_SIZE:0]  mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    pkt_count;
    logic                wr_en;
    logic                rd_en;
    logic                pkt_in;
    logic                pkt_out;

    assign data_in_tready = (count != FULL_CNT);

    // In packet mode a complete packet must be stored before release; a full FIFO
    // releases regardless so that packets longer than DEPTH cannot deadlock.
    assign data_out_tvalid = (count != '0) &
                             ((PACKET_MODE == 0) | (pkt_count != '0) | (count == FULL_CNT));

    assign wr_en   = data_in_tvalid & data_in_tready;
    assign rd_en   = data_out_tvalid & data_out_tready;
    assign pkt_in  = wr_en & data_in_tlast;
    assign pkt_out = rd_en & data_out_tlast;

    assign {data_out_tlast, data_out_tdata} = mem[rd_ptr];
    assign fill_level_o  = count;
    assign almost_full_o = (count >= AF_CNT);

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= {data_in_tlast, data_in_tdata};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pkt_count <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
            case ({pkt_in, pkt_out})
                2'b10:   pkt_count <= pkt_count + ONE;
                2'b01:   pkt_count <= pkt_count - ONE;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_stream_sync_fifo.sv
// Scoreboard bench: a cut-through and a packet-mode FIFO, each checked every cycle
// against a queue model of the stored beats.
module tb_axi4_stream_sync_fifo;

    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int AF = DEPTH - 2;
    localparam int NBEATS = 4096;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in_data   [2];
    logic          in_last   [2];
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [DW-1:0] out_data  [2];
    logic          out_last  [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [4:0]    fill      [2];
    logic          afull     [2];

    int checks = 0;
    int fails = 0;
    int sb_size [2];

    always #5 clk = ~clk;

    axi4_stream_sync_fifo #(.DATA_SIZE(DW), .DEPTH(DEPTH), .PACKET_MODE(0), .ALMOST_FULL_THRESH(AF)) u_ct (
        .clk_i(clk), .rst_ni(rst_n),
        .data_in_tdata(in_data[0]), .data_in_tlast(in_last[0]),
        .data_in_tvalid(in_valid[0]), .data_in_tready(in_ready[0]),
        .data_out_tdata(out_data[0]), .data_out_tlast(out_last[0]),
        .data_out_tvalid(out_valid[0]), .data_out_tready(out_ready[0]),
        .fill_level_o(fill[0]), .almost_full_o(afull[0])
    );

    axi4_stream_sync_fifo #(.DATA_SIZE(DW), .DEPTH(DEPTH), .PACKET_MODE(1), .ALMOST_FULL_THRESH(AF)) u_pk (
        .clk_i(clk), .rst_ni(rst_n),
        .data_in_tdata(in_data[1]), .data_in_tlast(in_last[1]),
        .data_in_tvalid(in_valid[1]), .data_in_tready(in_ready[1]),
        .data_out_tdata(out_data[1]), .data_out_tlast(out_last[1]),
        .data_out_tvalid(out_valid[1]), .data_out_tready(out_ready[1]),
        .fill_level_o(fill[1]), .almost_full_o(afull[1])
    );

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, d, $time, act, exp);
        end
    endtask

    // Monitor + reference model: the queue holds exactly the beats the FIFO should hold.
    for (genvar g = 0; g < 2; g++) begin : mon
        logic [DW:0] q[$];
        bit seen_rst = 0;
        always @(negedge clk) begin
            int pk;
            bit exp_v;
            if (!rst_n) begin
                seen_rst = 1;
                q.delete();
            end else if (seen_rst) begin
                pk = 0;
                foreach (q[i]) if (q[i][DW]) pk++;
                chk("fill_level", g, 32'(fill[g]), 32'(q.size()));
                chk("in_tready", g, 32'(in_ready[g]), 32'(q.size() != DEPTH));
                chk("almost_full", g, 32'(afull[g]), 32'(q.size() >= AF));
                exp_v = (q.size() != 0) && ((g == 0) || (pk != 0) || (q.size() == DEPTH));
                chk("out_tvalid", g, 32'(out_valid[g]), 32'(exp_v));
                if (out_valid[g] && out_ready[g]) begin
                    if (q.size() == 0) begin
                        chk("read_from_empty", g, 32'(1), 32'(0));
                    end else begin
                        chk("out_tdata", g, 32'(out_data[g]), 32'(q[0][DW-1:0]));
                        chk("out_tlast", g, 32'(out_last[g]), 32'(q[0][DW]));
                        void'(q.pop_front());
                    end
                end
                if (in_valid[g] && in_ready[g]) q.push_back({in_last[g], in_data[g]});
            end
            sb_size[g] = q.size();
        end
    end

    task automatic put(input int d, input logic [DW-1:0] v, input logic l);
        in_valid[d] = 1'b1;
        in_data[d]  = v;
        in_last[d]  = l;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (in_ready[d]) begin
                @(posedge clk); #1;
                in_valid[d] = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid[d] = 1'b0;
        chk("put_timeout", d, 32'(1), 32'(0));
    endtask

    task automatic wait_empty(input int d);
        for (int t = 0; t < 500; t++) begin
            @(posedge clk); #1;
            if (sb_size[d] == 0) return;
        end
        chk("drain_timeout", d, 32'(sb_size[d]), 32'(0));
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic rand_run(input int d);
        int beat = 0;
        int cyc = 0;
        bit done = 0;
        fork
            begin
                while (!done) begin
                    out_ready[d] = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
                out_ready[d] = 1'b1;
            end
            begin
                while (beat < NBEATS && cyc < 40000) begin
                    bit acc = 0;
                    if (!in_valid[d] && $urandom_range(0, 1) == 1) begin
                        in_valid[d] = 1'b1;
                        in_data[d]  = DW'($urandom);
                        in_last[d]  = (beat % 5 == 4) || (beat == NBEATS - 1);
                    end
                    @(negedge clk);
                    if (in_valid[d] && in_ready[d]) begin
                        beat++;
                        acc = 1;
                    end
                    @(posedge clk); #1;
                    if (acc) in_valid[d] = 1'b0;
                    cyc++;
                end
                in_valid[d] = 1'b0;
                done = 1;
                if (beat < NBEATS) chk("random_timeout", d, 32'(beat), 32'(NBEATS));
            end
        join
        wait_empty(d);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            in_data[d] = '0; in_last[d] = 1'b0; in_valid[d] = 1'b1; out_ready[d] = 1'b0;
        end
        // Reset held for three edges with writes offered: nothing may be stored.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_valid[0] = 1'b0; in_valid[1] = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_tready", 0, 32'(in_ready[0]), 32'(1));
        chk("reset_tvalid", 0, 32'(out_valid[0]), 32'(0));
        chk("reset_level", 1, 32'(fill[1]), 32'(0));
        @(posedge clk); #1;

        // Fill to full with the reader stalled, then offer one more beat.
        for (int i = 0; i < DEPTH; i++) put(0, DW'(i), 1'b0);
        in_valid[0] = 1'b1; in_data[0] = 8'hEE;
        idle(3);
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        wait_empty(0);
        idle(2);

        // Steady state at level 8 with simultaneous read and write.
        out_ready[0] = 1'b0;
        for (int i = 0; i < 8; i++) put(0, DW'(8'h80 + i), 1'b0);
        out_ready[0] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid[0] = 1'b1; in_data[0] = DW'(i); in_last[0] = 1'(i % 3 == 0);
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        wait_empty(0);

        // Reset mid-operation discards stored beats.
        out_ready[0] = 1'b0;
        for (int i = 0; i < 5; i++) put(0, DW'(8'h50 + i), 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_level", 0, 32'(fill[0]), 32'(0));
        @(posedge clk); #1;

        // Store-and-forward: three non-last beats are held back until tlast arrives.
        out_ready[1] = 1'b1;
        for (int i = 0; i < 3; i++) put(1, DW'(8'hA0 + i), 1'b0);
        idle(3);
        put(1, 8'hA3, 1'b1);
        wait_empty(1);

        // Packet longer than the FIFO must flow once it fills.
        for (int i = 0; i < 20; i++) put(1, DW'(8'hC0 + i), 1'(i == 19));
        wait_empty(1);
        idle(2);

        fork
            rand_run(0);
            rand_run(1);
        join
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/axi4_stream_sync_fifo.md
Name: axi4_stream_sync_fifo

Overview:
- Single-clock, parametrised AXI4-Stream FIFO; the next generation of the team's axi4_stream_fifo for same-clock-domain buffering.
- Adds a tlast sideband, configurable depth, and an optional store-and-forward packet mode.
- Adds fill-level and almost-full status outputs for upstream flow control and debug.
- Sits between an AXI4-Stream master and slave running on clk_i.

Parameters:
- DATA_SIZE, 8, tdata width in bits; must be >= 1.
- DEPTH, 16, number of entries; power of two, >= 2.
- PACKET_MODE, 0, 0 = cut-through, 1 = store-and-forward on tlast.
- ALMOST_FULL_THRESH, DEPTH-2, fill level at or above which almost_full_o asserts; range 1..DEPTH.

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_ni  in  1  synchronous active-low reset.
- data_in_tdata  in  DATA_SIZE  write data.
- data_in_tlast  in  1  last beat of packet.
- data_in_tvalid  in  1  write valid.
- data_in_tready  out  1  FIFO can accept.
- data_out_tdata  out  DATA_SIZE  read data.
- data_out_tlast  out  1  tlast stored with the read beat.
- data_out_tvalid  out  1  read valid.
- data_out_tready  in  1  downstream accepts.
- fill_level_o  out  $clog2(DEPTH)+1  entries currently stored, 0..DEPTH.
- almost_full_o  out  1  fill_level_o >= ALMOST_FULL_THRESH.

Behaviour:
- Interface: one clock domain (clk_i); reset rst_ni is synchronous and active-low.
- Reset (rst_ni=0 at a clk_i edge):
  - Pointers, fill count and packet count clear.
  - Outputs after the edge: data_in_tready=1, data_out_tvalid=0, fill_level_o=0, almost_full_o=0.
  - data_out_tdata and data_out_tlast are don't-care while data_out_tvalid=0.
  - Reset mid-operation discards all stored beats.
  - Reset has priority over simultaneous handshakes.
- Write handshake: data_in_tvalid & data_in_tready at an edge. Stores {tlast, tdata} at wr_ptr; wr_ptr increments modulo DEPTH.
- Read handshake: data_out_tvalid & data_out_tready at an edge. rd_ptr increments modulo DEPTH.
- Pointers: $clog2(DEPTH) bits and wrap naturally.
- Fill count: width $clog2(DEPTH)+1. +1 on write only, -1 on read only, unchanged when both happen in the same cycle.
- data_in_tready = (count != DEPTH). Combinational from registered state; no dependence on data_out_tready, so no full-bypass.
- Read data is first-word fall-through: data_out_tdata/tlast driven combinationally from mem[rd_ptr].
- Write-to-output latency: a beat written at edge N is visible on data_out at N+1 (in cut-through mode).
- PACKET_MODE=0: data_out_tvalid = (count != 0).
- PACKET_MODE=1:
  - pkt_count (width $clog2(DEPTH)+1) increments on a write handshake with tlast=1.
  - pkt_count decrements on a read handshake with tlast=1; both in the same cycle leaves it unchanged.
  - data_out_tvalid = (count != 0) & ((pkt_count != 0) | (count == DEPTH)).
  - The full override prevents deadlock on packets longer than DEPTH; those flow cut-through once the FIFO fills.
  - Once a beat is presented valid, valid stays high until accepted.
- AXI rules:
  - data_out_tvalid never deasserts without a handshake, except on reset.
  - data_out_tdata/tlast are stable while valid & !ready.
- fill_level_o = count, registered.
- almost_full_o: combinational compare of count against ALMOST_FULL_THRESH.
- Boundary conditions:
  - Write when full: tready=0, no store.
  - Read when empty: tvalid=0, no pointer move.
  - Full with simultaneous read: no write that cycle; count goes DEPTH-1.
  - Empty with write: count goes 1; no same-cycle pass-through.

Test Plan:
- Reset with DEPTH=16: hold rst_ni=0 for 3 edges while data_in_tvalid=1 -> after release tready=1, tvalid=0, fill_level_o=0, nothing stored.
- Fill then drain with data_out_tready=0:
  - Write 0x00..0x0F -> tready falls after the 16th write; fill_level_o=16; almost_full_o=1 from level 14.
  - Then ready=1 -> outputs 0x00..0x0F in order; tvalid drops after the 16th read.
- Simultaneous read/write at level 8 for 100 cycles -> fill_level_o stays 8; order preserved.
- Wrap test: random valid/ready, 4096 beats with tlast every 5th beat -> output data and tlast match the input scoreboard exactly.
- PACKET_MODE=1, write 3 beats with tlast=0 -> tvalid stays 0; 4th beat with tlast=1 -> tvalid=1 next cycle; four beats read with tlast on the 4th.
- PACKET_MODE=1, DEPTH=16, 20-beat packet -> tvalid asserts when count hits 16; all 20 beats delivered; no deadlock.
